// File: rtl/cordic_pkg.sv
// Shared constants, FSM states and range-shift helper for the linear-mode CORDIC units.
package cordic_pkg;
    localparam int FLOAT_SIZE = 24;
    localparam int INT_SIZE   = 8;
    localparam int GUARD      = 8;
    localparam int W          = INT_SIZE + FLOAT_SIZE;
    localparam int IW         = W + GUARD;
    localparam int FRAC       = FLOAT_SIZE + GUARD;
    localparam int YW         = IW + INT_SIZE + 2;
    localparam int ITERS      = FLOAT_SIZE + INT_SIZE;
    localparam int CW         = $clog2(ITERS);
    localparam int SW         = (INT_SIZE > 1) ? $clog2(INT_SIZE) : 1;

    typedef enum logic [2:0] {ST_IDLE, ST_PREP, ST_ITER, ST_POST, ST_DONE} cordic_state_e;

    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    // Smallest s such that b/2^s lies in [-1.0, 1.0]; scanning down leaves the smallest match.
    function automatic logic [SW-1:0] range_shift(input logic signed [W-1:0] b);
        logic signed [W+1:0] bx;
        logic signed [W+1:0] lim;
        logic [SW-1:0]       s_sel;
        bx    = (W+2)'(b);
        s_sel = SW'(INT_SIZE - 1);
        for (int s = INT_SIZE - 1; s >= 0; s--) begin
            lim = (W+2)'(1) <<< (FLOAT_SIZE + s);
            if (bx >= -lim && bx <= lim) s_sel = SW'(s);
        end
        return s_sel;
    endfunction
endpackage

// File: rtl/cordic_linear_stage.sv
// One linear-rotation micro-step: y += d*(x>>>i), z -= d*2^-i, d from sign of z.
module cordic_linear_stage
    import cordic_pkg::*;
(
    input  logic signed [IW-1:0] x,
    input  logic signed [YW-1:0] y,
    input  logic signed [IW-1:0] z,
    input  logic        [CW-1:0] i,
    output logic signed [YW-1:0] y_next,
    output logic signed [IW-1:0] z_next
);
    logic signed [YW-1:0] xs;
    logic signed [IW-1:0] step;

    always_comb begin
        xs   = YW'(x);
        xs   = xs >>> i;
        step = IW'(1) << (FRAC - int'(i));
        if (!z[IW-1]) begin
            y_next = y + xs;
            z_next = z - step;
        end else begin
            y_next = y - xs;
            z_next = z + step;
        end
    end
endmodule

// File: rtl/cordic_multiplier.sv
// Iterative CORDIC linear-rotation multiplier, out = a*b in signed Q8.24.
// Define CORDIC_MUL_SAT_EN to saturate out on overflow instead of wrapping.
module cordic_multiplier
    import cordic_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] out,
    output logic         done,
    output logic         ovf
);
    cordic_state_e        state_q, state_d;
    logic signed [W-1:0]  a_q, a_d, b_q, b_d;
    logic        [SW-1:0] s_q, s_d, s_pick;
    logic signed [IW-1:0] x_q, x_d, z_q, z_d, z_nx;
    logic signed [YW-1:0] y_q, y_d, y_nx, p, q;
    logic        [CW-1:0] i_q, i_d;
    logic        [W-1:0]  res_q, res_d, out_q, out_d;
    logic                 rovf_q, rovf_d, ovf_q, ovf_d, done_q, done_d, q_ovf;

    cordic_linear_stage u_stage (
        .x(x_q), .y(y_q), .z(z_q), .i(i_q), .y_next(y_nx), .z_next(z_nx)
    );

    always_comb begin
        state_d = state_q;
        a_d = a_q;  b_d = b_q;  s_d = s_q;
        x_d = x_q;  y_d = y_q;  z_d = z_q;  i_d = i_q;
        res_d = res_q;  rovf_d = rovf_q;
        out_d = out_q;  ovf_d = ovf_q;  done_d = 1'b0;
        s_pick = range_shift(b_q);
        // b = 0 would otherwise leave a tiny residual that floors to -1 LSB for negative a
        p = y_q <<< s_q;
        q = p >>> GUARD;
        if (b_q == '0) q = '0;
        q_ovf = !((&q[YW-1:W-1]) || !(|q[YW-1:W-1]));
        case (state_q)
            ST_IDLE: if (start) begin
                a_d     = a;
                b_d     = b;
                state_d = ST_PREP;
            end
            ST_PREP: begin
                s_d     = s_pick;
                x_d     = {a_q, {GUARD{1'b0}}};
                z_d     = $signed({b_q, {GUARD{1'b0}}}) >>> s_pick;
                y_d     = '0;
                i_d     = '0;
                state_d = ST_ITER;
            end
            ST_ITER: begin
                y_d = y_nx;
                z_d = z_nx;
                i_d = i_q + 1'b1;
                if (i_q == CW'(ITERS - 1)) state_d = ST_POST;
            end
            ST_POST: begin
                rovf_d = q_ovf;
`ifdef CORDIC_MUL_SAT_EN
                res_d  = q_ovf ? (q[YW-1] ? SAT_MIN : SAT_MAX) : q[W-1:0];
`else
                res_d  = q[W-1:0];
`endif
                state_d = ST_DONE;
            end
            ST_DONE: begin
                out_d   = res_q;
                ovf_d   = rovf_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            a_q <= '0;  b_q <= '0;  s_q <= '0;
            x_q <= '0;  y_q <= '0;  z_q <= '0;  i_q <= '0;
            res_q <= '0;  rovf_q <= 1'b0;
            out_q <= '0;  ovf_q <= 1'b0;  done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;  b_q <= b_d;  s_q <= s_d;
            x_q <= x_d;  y_q <= y_d;  z_q <= z_d;  i_q <= i_d;
            res_q <= res_d;  rovf_q <= rovf_d;
            out_q <= out_d;  ovf_q <= ovf_d;  done_q <= done_d;
        end
    end

    assign out  = out_q;
    assign done = done_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_cordic_multiplier.sv
// Self-checking bench for cordic_multiplier against an exact-product reference model.
module tb_cordic_multiplier;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [31:0] a_i = '0, b_i = '0;
    logic [31:0] out_o;
    logic        done_o, ovf_o;
    int          n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    cordic_multiplier dut (
        .clk(clk), .rst(rst), .start(start), .a(a_i), .b(b_i),
        .out(out_o), .done(done_o), .ovf(ovf_o)
    );

    function automatic longint exact_q(input logic [31:0] a, input logic [31:0] b);
        longint pr;
        pr = longint'($signed(a)) * longint'($signed(b));
        return pr >>> 24;
    endfunction

    function automatic bit model_ovf(input longint e);
        return (e > 64'sd2147483647) || (e < -64'sd2147483648);
    endfunction

    function automatic logic [31:0] model_out(input longint e);
        logic [63:0] ev;
        ev = e;
`ifdef CORDIC_MUL_SAT_EN
        if (model_ovf(e)) return (e < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return ev[31:0];
    endfunction

    function automatic int lsb_err(input logic [31:0] got, input logic [31:0] exp);
        logic signed [31:0] d;
        d = got - exp;
        return (d < 0) ? -int'(d) : int'(d);
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                          output logic [31:0] o, output logic ov, output int lat,
                          output logic d2);
        @(negedge clk);
        a_i = a; b_i = b; start = 1'b1;
        @(posedge clk); #1;
        if (hold <= 1) start = 1'b0;
        lat = 0;
        while (!done_o && lat < 100) begin
            @(posedge clk); lat++; #1;
            if (lat >= hold - 1) start = 1'b0;
        end
        o = out_o; ov = ovf_o;
        @(posedge clk); #1;
        d2 = done_o;
    endtask

    task automatic test_reset;
        #3 rst = 1'b0;
        #1;
        n_checks++; if (out_o !== 32'h0) begin n_fail++; $display("FAIL reset_out got=%h exp=0", out_o); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done_o); end
        n_checks++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf_o); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_directed;
        logic [31:0] ta [5] = '{32'h0200_0000, 32'hFE80_0000, 32'h3F7A_E147, 32'h6400_0000, 32'h9C00_0000};
        logic [31:0] tb [5] = '{32'h0300_0000, 32'h0240_0000, 32'h0004_0863, 32'h0200_0000, 32'h0200_0000};
        int          tol [5] = '{2, 2, 64, 2, 2};
        bit          tov [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`ifdef CORDIC_MUL_SAT_EN
        logic [31:0] te [5] = '{32'h0600_0000, 32'hFCA0_0000, 32'h0100_0000, 32'h7FFF_FFFF, 32'h8000_0000};
`else
        logic [31:0] te [5] = '{32'h0600_0000, 32'hFCA0_0000, 32'h0100_0000, 32'hC800_0000, 32'h3800_0000};
`endif
        logic [31:0] o;
        logic        ov, d2;
        int          lat;
        for (int k = 0; k < 5; k++) begin
            run_op(ta[k], tb[k], 2, o, ov, lat, d2);
            n_checks++; if (lsb_err(o, te[k]) > tol[k]) begin n_fail++; $display("FAIL directed%0d_out got=%h exp=%h tol=%0d", k, o, te[k], tol[k]); end
            n_checks++; if (ov !== tov[k]) begin n_fail++; $display("FAIL directed%0d_ovf got=%b exp=%b", k, ov, tov[k]); end
            n_checks++; if (lat != 35) begin n_fail++; $display("FAIL directed%0d_latency got=%0d exp=35", k, lat); end
            n_checks++; if (d2 !== 1'b0) begin n_fail++; $display("FAIL directed%0d_done_width got=%b exp=0", k, d2); end
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b, o, e;
        logic        ov, d2;
        int          lat;
        longint      ex;
        for (int k = 0; k < 24; k++) begin
            a  = 32'($urandom_range(0, 32'h07FF_FFFF)) - 32'h0400_0000;
            b  = 32'($urandom_range(0, 32'h1FFF_FFFF)) - 32'h1000_0000;
            ex = exact_q(a, b);
            e  = model_out(ex);
            run_op(a, b, 1, o, ov, lat, d2);
            n_checks++; if (lsb_err(o, e) > 4) begin n_fail++; $display("FAIL random%0d_out a=%h b=%h got=%h exp=%h", k, a, b, o, e); end
            n_checks++; if (ov !== model_ovf(ex)) begin n_fail++; $display("FAIL random%0d_ovf got=%b exp=%b", k, ov, model_ovf(ex)); end
            n_checks++; if (lat != 35) begin n_fail++; $display("FAIL random%0d_latency got=%0d exp=35", k, lat); end
        end
    endtask

    task automatic test_reset_mid_op;
        logic [31:0] o;
        logic        ov, d2;
        int          lat, stale;
        @(negedge clk);
        a_i = 32'h0200_0000; b_i = 32'h0300_0000; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        n_checks++; if (out_o !== 32'h0) begin n_fail++; $display("FAIL midreset_out got=%h exp=0", out_o); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL midreset_done got=%b exp=0", done_o); end
        n_checks++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL midreset_ovf got=%b exp=0", ovf_o); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        stale = 0;
        repeat (50) begin @(posedge clk); #1; if (done_o) stale++; end
        n_checks++; if (stale != 0) begin n_fail++; $display("FAIL midreset_stale_done got=%0d exp=0", stale); end
        run_op(32'hFE80_0000, 32'h0400_0000, 1, o, ov, lat, d2);
        n_checks++; if (lsb_err(o, 32'hFA00_0000) > 2) begin n_fail++; $display("FAIL midreset_rerun_out got=%h exp=fa000000", o); end
        n_checks++; if (lat != 35) begin n_fail++; $display("FAIL midreset_rerun_latency got=%0d exp=35", lat); end
    endtask

    task automatic test_start_ignored;
        logic [31:0] o;
        logic        ov, d2;
        int          n, first, pulses, lat;
        @(negedge clk);
        a_i = 32'($urandom_range(0, 32'h07FF_FFFF)) - 32'h0400_0000; b_i = 32'h0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0; first = -1; pulses = 0; o = 'x; ov = 'x;
        while (n < 80) begin
            @(posedge clk); n++; #1;
            start = (n == 5);
            if (done_o) begin
                pulses++;
                if (first < 0) begin first = n; o = out_o; ov = ovf_o; end
            end
        end
        n_checks++; if (first != 35) begin n_fail++; $display("FAIL ignored_latency got=%0d exp=35", first); end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL ignored_pulses got=%0d exp=1", pulses); end
        n_checks++; if (o !== 32'h0) begin n_fail++; $display("FAIL bzero_out got=%h exp=0", o); end
        n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL bzero_ovf got=%b exp=0", ov); end
        run_op(32'h0, $urandom(), 1, o, ov, lat, d2);
        n_checks++; if (o !== 32'h0) begin n_fail++; $display("FAIL azero_out got=%h exp=0", o); end
        run_op(32'h0100_0000, 32'h8000_0000, 1, o, ov, lat, d2);
        n_checks++; if (lsb_err(o, 32'h8000_0000) > 2) begin n_fail++; $display("FAIL bmin_out got=%h exp=80000000", o); end
        n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL bmin_ovf got=%b exp=0", ov); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r1, r2;
        int          n, first, second, pulses;
        @(negedge clk);
        a_i = 32'h0200_0000; b_i = 32'h0180_0000; start = 1'b1;
        @(posedge clk); #1;
        n = 0; first = -1; second = -1; pulses = 0; r1 = 'x; r2 = 'x;
        while (n < 90) begin
            @(posedge clk); n++; #1;
            if (done_o) begin
                pulses++;
                if (first < 0) begin
                    first = n; r1 = out_o;
                    a_i = 32'hFF00_0000; b_i = 32'h0500_0000;
                end else if (second < 0) begin
                    second = n; r2 = out_o;
                end
            end
            if (n == 36) start = 1'b0;
        end
        n_checks++; if (first != 35) begin n_fail++; $display("FAIL b2b_first_latency got=%0d exp=35", first); end
        n_checks++; if (second != 71) begin n_fail++; $display("FAIL b2b_second_latency got=%0d exp=71", second); end
        n_checks++; if (pulses != 2) begin n_fail++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
        n_checks++; if (lsb_err(r1, 32'h0300_0000) > 2) begin n_fail++; $display("FAIL b2b_first_out got=%h exp=03000000", r1); end
        n_checks++; if (lsb_err(r2, 32'hFB00_0000) > 2) begin n_fail++; $display("FAIL b2b_second_out got=%h exp=fb000000", r2); end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_reset_mid_op;
        test_start_ignored;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
